mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the instruction/data port arbiter.
//   mem_req   : request, held high until the cycle mem_ack is seen
//   mem_we    : 1 = store, 0 = load/fetch
//   mem_size  : access size code (3'b010 = word)
//   mem_addr  : access address
//   mem_wdata : store data
//   mem_ack   : completion from memory; mem_rdata is valid in this cycle
//   mem_rdata : read data
// master modport: the arbiter side. slave modport: the memory side.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [2:0]        mem_size;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_ack;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch requester (i_*) and a
// data requester (d_*). One transaction at a time: grant cycle, one or more
// wait cycles until mem_ack, then a one-cycle done pulse to the owner.
// Data normally wins; after MAX_DBURST back-to-back data grants with a fetch
// waiting, the fetch wins once.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_req/i_addr     : fetch request and address (held until i_done)
//   i_rdata/i_done   : fetch data and one-cycle completion pulse
//   d_req/d_we/d_size/d_addr/d_wdata : data request fields (held until d_done)
//   d_rdata/d_done   : load data and one-cycle completion pulse
//   mem              : memory bus (master modport)
//   stall_if/stall_mem : pipeline stall requests (combinational)
module mem_port_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [AWIDTH-1:0]      i_addr,
  output logic [DWIDTH-1:0]      i_rdata,
  output logic                   i_done,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [2:0]             d_size,
  input  logic [AWIDTH-1:0]      d_addr,
  input  logic [DWIDTH-1:0]      d_wdata,
  output logic [DWIDTH-1:0]      d_rdata,
  output logic                   d_done,
  mem_port_arbiter_if.master     mem,
  output logic                   stall_if,
  output logic                   stall_mem
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

  localparam logic [3:0] DBURST_MAX = 4'(MAX_DBURST);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  state_t     state_reg;
  logic [3:0] dcount_reg;
  // Set for the single IDLE cycle that follows a done pulse of that side.
  logic       i_mask_reg;
  logic       d_mask_reg;

  logic i_wins;
  logic grant_i;
  logic grant_d;

  // Priority is decided on the raw requests. A masked requester keeps its
  // priority slot for that cycle: if it would have won, nobody is granted, so
  // a stale request is never reissued and the other side does not jump the
  // queue just because of the one-cycle mask.
  always_comb begin
    i_wins  = i_req && (!d_req || (dcount_reg == DBURST_MAX));
    grant_i = (state_reg == IDLE) && i_wins && !i_mask_reg;
    grant_d = (state_reg == IDLE) && !i_wins && d_req && !d_mask_reg;
  end

  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      dcount_reg    <= '0;
      i_mask_reg    <= 1'b0;
      d_mask_reg    <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_size  <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      i_rdata       <= '0;
      d_rdata       <= '0;
    end else begin
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_mask_reg <= 1'b0;
      d_mask_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_i) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_size  <= SIZE_WORD;
            mem.mem_addr  <= i_addr;
            mem.mem_wdata <= '0;
            dcount_reg    <= '0;
            state_reg     <= IBUSY;
          end else if (grant_d) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= d_we;
            mem.mem_size  <= d_size;
            mem.mem_addr  <= d_addr;
            mem.mem_wdata <= d_wdata;
            // Count only grants that made a waiting fetch wait longer.
            if (!i_req) begin
              dcount_reg <= '0;
            end else if (dcount_reg != DBURST_MAX) begin
              dcount_reg <= dcount_reg + 4'd1;
            end
            state_reg <= DBUSY;
          end
        end
        IBUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            i_rdata     <= mem.mem_rdata;
            i_done      <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DBUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            d_rdata     <= mem.mem_rdata;
            d_done      <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          // The requester still shows its old request in the next cycle.
          i_mask_reg <= i_done;
          d_mask_reg <= d_done;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_size;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, d_done, stall_if, stall_mem;

  mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) mif ();

  mem_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .MAX_DBURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem(mif), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: phase of the current transaction
  // (0 none, 1 waiting on memory, 2 completion cycle), its owner and fields.
  int          phase = 0;
  bit          owner_d;
  int          just_done = 0;   // 1 fetch, 2 data: completed in the last cycle
  int          mdc = 0;         // data grants in a row while a fetch waited
  logic        e_we;
  logic [2:0]  e_size;
  logic [31:0] e_addr, e_wdata, exp_i_rdata, exp_d_rdata;
  string       order = "";
  int          txn_count = 0;

  // Memory responder controls.
  bit          random_mode = 0;
  bit          spurious_dir = 0;
  int          ack_delay_dir = 1;
  logic [31:0] rdata_dir = '0;
  int          mem_cnt = 0;
  int          mem_delay = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs after the edge, compare with the reference,
  // then drive the next cycle's memory response and (random mode) requests.
  task automatic step();
    bit f_wins, want;
    @(negedge clk);
    if (rst) begin
      chk("rst_mem_req", mif.mem_req, 0);
      chk("rst_mem_we", mif.mem_we, 0);
      chk("rst_mem_size", mif.mem_size, 0);
      chk("rst_mem_addr", mif.mem_addr, 0);
      chk("rst_mem_wdata", mif.mem_wdata, 0);
      chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0);
      phase = 0; mdc = 0; just_done = 0;
      exp_i_rdata = '0; exp_d_rdata = '0;
    end else begin
      case (phase)
        0: begin
          f_wins = i_req && (!d_req || mdc == MAXB);
          want   = f_wins ? (just_done != 1) : (d_req && just_done != 2);
          just_done = 0;
          chk("grant", mif.mem_req, want);
          chk("idle_i_done", i_done, 0);
          chk("idle_d_done", d_done, 0);
          if (want) begin
            owner_d = !f_wins;
            if (f_wins) begin
              e_we = 0; e_size = 3'b010; e_addr = i_addr; e_wdata = '0;
              mdc = 0; order = {order, "I"};
            end else begin
              e_we = d_we; e_size = d_size; e_addr = d_addr; e_wdata = d_wdata;
              mdc = i_req ? ((mdc < MAXB) ? mdc + 1 : MAXB) : 0;
              order = {order, "D"};
            end
            txn_count++;
            phase = 1;
            chk("grant_addr", mif.mem_addr, e_addr);
            chk("grant_we", mif.mem_we, e_we);
            chk("grant_size", mif.mem_size, e_size);
            if (owner_d) chk("grant_wdata", mif.mem_wdata, e_wdata);
          end
        end
        1: begin
          if (mif.mem_ack) begin
            chk("done_mem_req", mif.mem_req, 0);
            chk("done_i", i_done, !owner_d);
            chk("done_d", d_done, owner_d);
            if (owner_d) exp_d_rdata = mif.mem_rdata;
            else exp_i_rdata = mif.mem_rdata;
            phase = 2;
          end else begin
            chk("hold_mem_req", mif.mem_req, 1);
            chk("hold_addr", mif.mem_addr, e_addr);
            chk("hold_we", mif.mem_we, e_we);
            chk("hold_size", mif.mem_size, e_size);
            if (owner_d) chk("hold_wdata", mif.mem_wdata, e_wdata);
            chk("wait_i_done", i_done, 0);
            chk("wait_d_done", d_done, 0);
          end
        end
        default: begin
          chk("post_mem_req", mif.mem_req, 0);
          chk("post_i_done", i_done, 0);
          chk("post_d_done", d_done, 0);
          just_done = owner_d ? 2 : 1;
          phase = 0;
        end
      endcase
      chk("stall_if", stall_if, i_req & ~i_done);
      chk("stall_mem", stall_mem, d_req & ~d_done);
    end
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);

    if (mif.mem_req) begin
      if (mem_cnt == 0) mem_delay = random_mode ? int'($urandom_range(0, 3)) : ack_delay_dir;
      mif.mem_ack = (mem_cnt == mem_delay);
      mem_cnt++;
    end else begin
      mem_cnt = 0;
      mif.mem_ack = random_mode ? ($urandom_range(0, 3) == 0) : spurious_dir;
    end
    mif.mem_rdata = random_mode ? $urandom : rdata_dir;

    if (random_mode) begin
      if (i_done) begin
        if ($urandom_range(0, 1) == 1) i_addr = $urandom;
        else i_req = 0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_done) begin
        if ($urandom_range(0, 1) == 1) begin
          d_we = 1'($urandom_range(0, 1)); d_size = 3'($urandom_range(0, 7));
          d_addr = $urandom; d_wdata = $urandom;
        end else d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_size = 3'($urandom_range(0, 7));
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
  endtask

  task automatic run_until_done(input string tag, output bit got_i, output bit got_d);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!i_done && !d_done && n < 60);
    got_i = i_done;
    got_d = d_done;
    chk(tag, i_done | d_done, 1);
  endtask

  initial begin
    bit gi, gd;
    int base;
    rst = 1; i_req = 0; d_req = 0; d_we = 0; d_size = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mif.mem_ack = 0; mif.mem_rdata = '0;

    step(); step();
    rst = 0;

    // Spurious ack while idle.
    spurious_dir = 1;
    repeat (3) step();
    spurious_dir = 0;
    step();
    chk("spurious_no_txn", txn_count, 0);

    // Single fetch.
    i_req = 1; i_addr = 32'h100; ack_delay_dir = 2; rdata_dir = 32'h00500093;
    step();
    chk("fetch_mem_req", mif.mem_req, 1);
    chk("fetch_mem_addr", mif.mem_addr, 32'h100);
    chk("fetch_mem_we", mif.mem_we, 0);
    run_until_done("fetch_done", gi, gd);
    chk("fetch_is_i", gi, 1);
    chk("fetch_rdata", i_rdata, 32'h00500093);
    i_req = 0;
    step();
    chk("fetch_stall_after", stall_if, 0);

    // Simultaneous requests: data first, then fetch.
    order = "";
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 1; d_size = 3'b010; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    rdata_dir = 32'h11112222;
    step();
    chk("both_mem_we", mif.mem_we, 1);
    chk("both_mem_wdata", mif.mem_wdata, 32'hDEADBEEF);
    run_until_done("both_first", gi, gd);
    chk("both_first_is_d", gd, 1);
    d_req = 0;
    run_until_done("both_second", gi, gd);
    chk("both_second_is_i", gi, 1);
    i_req = 0;
    step();
    assert (order == "DI") else begin errors++; $error("FAIL both_order: observed=%s expected=DI", order); end
    checks++;

    // Starvation guard with both requesters held.
    order = ""; ack_delay_dir = 0;
    i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 10; k++) begin
      run_until_done("burst_done", gi, gd);
      d_addr = d_addr + 32'd4;
    end
    i_req = 0; d_req = 0;
    step(); step();
    assert (order == "DDDDIDDDDI") else begin errors++; $error("FAIL burst_order: observed=%s expected=DDDDIDDDDI", order); end
    checks++;

    // No duplicate reissue when the requester drops right after done.
    ack_delay_dir = 2;
    base = txn_count;
    d_req = 1; d_we = 0; d_addr = 32'h3000;
    run_until_done("nodup_d", gi, gd);
    d_req = 0;
    repeat (4) step();
    chk("nodup_d_count", txn_count - base, 1);
    base = txn_count;
    i_req = 1; i_addr = 32'h400;
    run_until_done("nodup_i", gi, gd);
    i_req = 0;
    repeat (4) step();
    chk("nodup_i_count", txn_count - base, 1);

    // Request dropped mid-transaction still completes.
    i_req = 1; i_addr = 32'h500;
    step(); step();
    i_req = 0;
    run_until_done("drop_mid", gi, gd);
    chk("drop_mid_is_i", gi, 1);
    step();

    // Reset while a data access waits on memory.
    d_req = 1; d_we = 1; d_addr = 32'h6000; d_wdata = 32'hCAFEF00D; ack_delay_dir = 5;
    step(); step();
    chk("pre_rst_mem_req", mif.mem_req, 1);
    rst = 1;
    step();
    rst = 0; d_req = 0;
    chk("post_rst_mem_req", mif.mem_req, 0);
    spurious_dir = 1;
    repeat (3) step();
    spurious_dir = 0;
    chk("post_rst_no_d_done", d_done, 0);

    // Randomized traffic against the reference.
    base = txn_count;
    random_mode = 1;
    repeat (4000) step();
    random_mode = 0;
    chk("random_progress", (txn_count - base) > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
